// File: rtl/gpio_input_pkg.sv
// Shared parameters and helpers for the push-button input conditioner.
// Imported by the per-channel debouncer and the multi-channel top.
package gpio_input_pkg;

    localparam int unsigned SYNC_DEPTH = 32'd2;

    // Counter width: the counter only needs to reach DEBOUNCE_CYCLES-1.
    function automatic int unsigned calc_cw(input int unsigned cycles);
        if (cycles < 32'd2) begin
            return 32'd1;
        end else begin
            return $clog2(cycles);
        end
    endfunction

endpackage

// File: rtl/gpio_debounce_channel.sv
// One button channel: synchroniser, polarity normalisation, stability counter,
// and registered level / press pulse / release pulse / sticky press flag.
module gpio_debounce_channel
    import gpio_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 32'd240000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic i_clk,
    input  logic i_resetn,
    input  logic i_button,
    input  logic i_clear,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_pressed
);

    localparam int unsigned   CW       = calc_cw(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 32'd1);
    localparam logic          IDLE_PIN = ACTIVE_LOW;

    logic [SYNC_DEPTH-1:0] r_sync;
    logic [CW-1:0]         r_count;
    logic                  r_stable;
    logic                  r_rise;
    logic                  r_fall;
    logic                  r_pressed;
    logic                  w_synced;
    logic                  w_commit;
    logic                  w_set;

    assign w_synced = r_sync[SYNC_DEPTH-1] ^ ACTIVE_LOW;
    assign w_commit = (w_synced != r_stable) && (r_count == CNT_MAX);
    assign w_set    = w_commit & w_synced;

    // Synchroniser resets to the released pin level so reset never looks like a press.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_sync <= {SYNC_DEPTH{IDLE_PIN}};
        end else begin
            r_sync <= {r_sync[SYNC_DEPTH-2:0], i_button};
        end
    end

    // Any return to the stable value restarts the window; a press beats a same-edge clear.
    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_count   <= '0;
            r_stable  <= 1'b0;
            r_rise    <= 1'b0;
            r_fall    <= 1'b0;
            r_pressed <= 1'b0;
        end else begin
            r_rise <= w_commit & w_synced;
            r_fall <= w_commit & ~w_synced;
            if (w_synced == r_stable) begin
                r_count <= '0;
            end else if (w_commit) begin
                r_count  <= '0;
                r_stable <= w_synced;
            end else begin
                r_count <= r_count + CW'(1);
            end
            if (w_set) begin
                r_pressed <= 1'b1;
            end else if (i_clear) begin
                r_pressed <= 1'b0;
            end else begin
                r_pressed <= r_pressed;
            end
        end
    end

    assign o_level   = r_stable;
    assign o_rise    = r_rise;
    assign o_fall    = r_fall;
    assign o_pressed = r_pressed;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Board-level button conditioner feeding the GPIO read bus: WIDTH independent
// debounced channels, each with level, press/release pulses and a sticky press flag.
module gpio_input_conditioner
    import gpio_input_pkg::*;
#(
    parameter int unsigned WIDTH           = 32'd2,
    parameter int unsigned DEBOUNCE_CYCLES = 32'd240000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic             io_mainClk,
    input  logic             io_resetn,
    input  logic [WIDTH-1:0] io_buttons,
    input  logic [WIDTH-1:0] io_clear,
    output logic [WIDTH-1:0] io_level,
    output logic [WIDTH-1:0] io_rise,
    output logic [WIDTH-1:0] io_fall,
    output logic [WIDTH-1:0] io_pressed
);

    if ((DEBOUNCE_CYCLES < 32'd2) || (DEBOUNCE_CYCLES > 32'd16777216)) begin : g_bad_cycles
        $error("gpio_input_conditioner: DEBOUNCE_CYCLES must be in 2..2^24");
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        gpio_debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_chan (
            .i_clk     (io_mainClk),
            .i_resetn  (io_resetn),
            .i_button  (io_buttons[g]),
            .i_clear   (io_clear[g]),
            .o_level   (io_level[g]),
            .o_rise    (io_rise[g]),
            .o_fall    (io_fall[g]),
            .o_pressed (io_pressed[g])
        );
    end

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Scoreboard bench for gpio_input_conditioner (WIDTH=2, DEBOUNCE_CYCLES=4, active-low).
// Each stimulus cycle queues the hand-computed outputs expected after that edge.
module tb_gpio_input_conditioner;

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] buttons;
    logic [1:0] clear;
    logic [1:0] level;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] pressed;

    logic [7:0] exp_q[$];
    string      tag_q[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;

    always #5 clk = ~clk;

    gpio_input_conditioner #(
        .WIDTH           (32'd2),
        .DEBOUNCE_CYCLES (32'd4),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .io_mainClk (clk),
        .io_resetn  (resetn),
        .io_buttons (buttons),
        .io_clear   (clear),
        .io_level   (level),
        .io_rise    (rise),
        .io_fall    (fall),
        .io_pressed (pressed)
    );

    // n cycles of the same inputs, each expecting {level, rise, fall, pressed} after its edge
    task automatic steps(input int n, input logic rn, input logic [1:0] b, input logic [1:0] c,
                         input logic [1:0] el, input logic [1:0] er, input logic [1:0] ef,
                         input logic [1:0] ep, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            resetn  = rn;
            buttons = b;
            clear   = c;
            exp_q.push_back({el, er, ef, ep});
            tag_q.push_back(tag);
        end
    endtask

    initial begin : monitor
        logic [7:0] e;
        string      t;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                total++;
                if ({level, rise, fall, pressed} !== e) begin
                    bad++;
                    $display("FAIL %s cycle=%0d got lvl=%b rise=%b fall=%b prs=%b want lvl=%b rise=%b fall=%b prs=%b",
                             t, cyc, level, rise, fall, pressed, e[7:6], e[5:4], e[3:2], e[1:0]);
                end
            end
        end
    end

    initial begin
        resetn  = 1'b0;
        buttons = 2'b11;
        clear   = 2'b00;

        steps(3,  1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "reset");
        steps(20, 1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "idle");

        // short glitch, then a glitch that would complete only with partial credit
        steps(3,  1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "glitch3");
        steps(6,  1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "glitch3_idle");
        steps(3,  1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "restart_a");
        steps(1,  1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "restart_gap");
        steps(3,  1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "restart_b");
        steps(6,  1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "restart_idle");

        steps(5,  1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "press_wait");
        steps(1,  1'b1, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, "press_edge");
        steps(4,  1'b1, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, "press_hold");

        steps(5,  1'b1, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, "release_wait");
        steps(1,  1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, "release_edge");
        steps(3,  1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, "sticky_hold");
        steps(1,  1'b1, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, "clear");
        steps(2,  1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "cleared");

        // clear held high across a press edge: the press must still be seen for one cycle
        steps(5,  1'b1, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, "setwin_wait");
        steps(1,  1'b1, 2'b10, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01, "setwin_edge");
        steps(3,  1'b1, 2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, "setwin_after");
        steps(5,  1'b1, 2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, "rel2_wait");
        steps(1,  1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, "rel2_edge");
        steps(2,  1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "rel2_idle");

        steps(5,  1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "both_wait");
        steps(1,  1'b1, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b11, "both_edge");
        steps(2,  1'b1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, "both_hold");
        steps(5,  1'b1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11, "both_rel_wait");
        steps(1,  1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11, "both_rel_edge");
        steps(2,  1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, "both_rel_idle");

        // one-cycle reset with the channel-0 counter at 2 discards the partial count
        steps(4,  1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, "midrst_count");
        steps(1,  1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "midrst_reset");
        steps(5,  1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "midrst_wait");
        steps(1,  1'b1, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, "midrst_edge");
        steps(2,  1'b1, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, "midrst_hold");

        @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
